csv_acc_resolve: RTL and testbench

CSV_ACC_RESOLVE -- requirements
Module: csv_acc_resolve

---
 rtl/csv_acc_resolve.sv | 119 +++++++++++
 tb/tb_csv_acc_resolve.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/csv_acc_resolve.sv
// Carry-save accumulator: folds (sum, carry) terms with 4:2 compression, then
// resolves AS+AC through a CHUNK-bit-per-cycle carry-propagate adder.
module csv_acc_resolve #(
  parameter int WIDTH = 16,
  parameter int ACC_W = 24,  // must be >= WIDTH and a multiple of CHUNK
  parameter int CHUNK = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_s_i,
  input  logic [WIDTH-1:0] in_c_i,
  input  logic             in_last_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [ACC_W-1:0] out_sum_o,
  output logic [7:0]       out_count_o
);

  localparam int NCH   = ACC_W / CHUNK;
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);

  typedef enum logic [1:0] {ACCUM, RESOLVE, OUTPUT} state_e;

  typedef struct packed {
    logic [ACC_W-1:0] s;
    logic [ACC_W-1:0] c;
  } csv_t;

  state_e           state_q, state_d;
  logic             live_q;
  csv_t             acc_q, cmp1, cmp2;
  logic [ACC_W-1:0] res_q;
  logic [IDX_W-1:0] idx_q;
  logic             cy_q;
  logic [7:0]       cnt_q;
  logic [ACC_W-1:0] ts, tc;
  logic [CHUNK-1:0] ca, cb, csum;
  logic             cout;
  logic             accept, last_chunk;

  assign ts = ACC_W'(in_s_i);
  assign tc = ACC_W'(in_c_i);

  // Two 3:2 layers form the 4:2 compressor; the left shift drops carries past ACC_W-1.
  always_comb begin
    cmp1.s = acc_q.s ^ acc_q.c ^ ts;
    cmp1.c = ((acc_q.s & acc_q.c) | (acc_q.s & ts) | (acc_q.c & ts)) << 1;
    cmp2.s = cmp1.s ^ cmp1.c ^ tc;
    cmp2.c = ((cmp1.s & cmp1.c) | (cmp1.s & tc) | (cmp1.c & tc)) << 1;
  end

  assign ca = acc_q.s[idx_q*CHUNK +: CHUNK];
  assign cb = acc_q.c[idx_q*CHUNK +: CHUNK];
  assign {cout, csum} = {1'b0, ca} + {1'b0, cb} + {{CHUNK{1'b0}}, cy_q};

  assign accept     = in_valid_i & in_ready_o;
  assign last_chunk = (idx_q == LAST_IDX);

  always_comb begin
    state_d     = state_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    out_sum_o   = '0;
    out_count_o = '0;
    case (state_q)
      ACCUM: begin
        // live_q holds ready low until the first edge after reset release
        in_ready_o = live_q;
        if (accept && in_last_i) state_d = RESOLVE;
      end
      RESOLVE: if (last_chunk) state_d = OUTPUT;
      OUTPUT: begin
        out_valid_o = 1'b1;
        out_sum_o   = res_q;
        out_count_o = cnt_q;
        if (out_ready_i) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ACCUM;
      live_q  <= 1'b0;
      acc_q   <= '0;
      res_q   <= '0;
      idx_q   <= '0;
      cy_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      case (state_q)
        ACCUM: if (accept) begin
          acc_q <= cmp2;
          if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
        end
        RESOLVE: begin
          res_q[idx_q*CHUNK +: CHUNK] <= csum;
          cy_q  <= cout;
          idx_q <= last_chunk ? '0 : idx_q + 1'b1;
        end
        OUTPUT: if (out_ready_i) begin
          acc_q <= '0;
          res_q <= '0;
          cnt_q <= '0;
          idx_q <= '0;
          cy_q  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csv_acc_resolve.sv
// Scoreboard bench for csv_acc_resolve: driver pushes expected group results,
// negedge monitor pops and compares on each output handshake.
module tb_csv_acc_resolve;
  localparam int WIDTH = 16;
  localparam int ACC_W = 24;
  localparam int CHUNK = 8;

  logic             clk = 0;
  logic             rst_n = 0;
  logic             in_valid = 0, in_ready, in_last = 0;
  logic [WIDTH-1:0] in_s = 0, in_c = 0;
  logic             out_valid, out_ready = 0;
  logic [ACC_W-1:0] out_sum;
  logic [7:0]       out_count;

  int checks = 0, failures = 0;
  bit rand_ready = 0;

  logic [ACC_W-1:0] exp_sum_q[$];
  logic [7:0]       exp_cnt_q[$];
  logic [ACC_W-1:0] model_sum = 0;
  int               model_cnt = 0;

  csv_acc_resolve #(.WIDTH(WIDTH), .ACC_W(ACC_W), .CHUNK(CHUNK)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_s_i(in_s), .in_c_i(in_c), .in_last_i(in_last),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_sum_o(out_sum), .out_count_o(out_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain modular sum of (s+c) over the group, count saturates at 255.
  task automatic send_term(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c, input logic last);
    int waitc = 0;
    in_valid = 1; in_s = s; in_c = c; in_last = last;
    while (!in_ready && waitc < 200) begin @(posedge clk); #1; waitc++; end
    if (!in_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      in_valid = 0; in_last = 0;
      return;
    end
    @(posedge clk);
    model_sum = model_sum + ACC_W'(s) + ACC_W'(c);
    model_cnt = (model_cnt < 255) ? model_cnt + 1 : 255;
    if (last) begin
      exp_sum_q.push_back(model_sum);
      exp_cnt_q.push_back(8'(model_cnt));
      model_sum = 0; model_cnt = 0;
    end
    #1 in_valid = 0; in_last = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_drain();
    int w = 0;
    while (exp_sum_q.size() != 0 && w < 3000) begin @(posedge clk); #1; w++; end
    check("drain_timeout", 32'(exp_sum_q.size()), 32'd0);
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: handshake compare, hold stability under back-pressure, zero when idle.
  bit               stalled = 0;
  logic [ACC_W-1:0] held_sum;
  logic [7:0]       held_cnt;
  always @(negedge clk) begin
    if (!rst_n) stalled = 0;
    else begin
      if (stalled) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_sum", 32'(out_sum), 32'(held_sum));
        check("stall_count", 32'(out_count), 32'(held_cnt));
      end
      stalled = 0;
      if (!out_valid) begin
        if (out_sum !== 0 || out_count !== 0)
          check("idle_zero", {out_count, out_sum}, 32'd0);
      end else if (out_ready) begin
        if (exp_sum_q.size() == 0) check("unexpected_output", 32'(out_sum), 32'hDEAD);
        else begin
          check("out_sum", 32'(out_sum), 32'(exp_sum_q.pop_front()));
          check("out_count", 32'(out_count), 32'(exp_cnt_q.pop_front()));
        end
      end else begin
        stalled = 1; held_sum = out_sum; held_cnt = out_count;
      end
    end
  end

  initial begin
    // reset state
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_zero", {out_count, out_sum}, 32'd0);
    #1 rst_n = 1;
    @(posedge clk); #1;
    check("ready_after_rst", 32'(in_ready), 32'd1);

    // single term, latency 3
    out_ready = 1;
    send_term(16'h00FF, 16'h0001, 1);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      check("latency_valid", 32'(out_valid), 32'(k == 3));
    end
    wait_drain();

    // three-term group
    send_term(16'h1234, 16'h0000, 0);
    send_term(16'h0001, 16'hFFFF, 0);
    send_term(16'h8000, 16'h8000, 1);
    wait_drain();

    // wrap and count saturation
    rand_ready = 1;
    for (int i = 0; i < 256; i++) send_term(16'hFFFF, 16'hFFFF, i == 255);
    wait_drain();

    // back-pressure while a term waits
    rand_ready = 0; idle(1); out_ready = 0;
    send_term(16'h0100, 16'h0200, 1);
    begin
      int w = 0;
      while (!out_valid && w < 20) begin @(posedge clk); #1; w++; end
    end
    check("stall_reached_output", 32'(out_valid), 32'd1);
    in_valid = 1; in_s = 16'h0005; in_c = 16'h0006; in_last = 1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1;
    @(posedge clk); #1;
    check("post_hs_ready", 32'(in_ready), 32'd1);
    check("post_hs_valid", 32'(out_valid), 32'd0);
    send_term(16'h0005, 16'h0006, 1);
    wait_drain();

    // reset in 2nd RESOLVE cycle abandons the group
    send_term(16'h0ABC, 16'h0001, 1);
    @(posedge clk); #2 rst_n = 0;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd0);
    check("midrst_zero", {out_count, out_sum}, 32'd0);
    exp_sum_q.delete(); exp_cnt_q.delete();
    model_sum = 0; model_cnt = 0;
    #3 rst_n = 1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("midrst_no_pulse", 32'(out_valid), 32'd0);
      check("midrst_ready_back", 32'(in_ready), 32'd1);
    end
    send_term(16'h0010, 16'h0020, 1);
    wait_drain();

    // randomized groups with gaps and random back-pressure
    rand_ready = 1;
    for (int g = 0; g < 40; g++) begin
      int n = $urandom_range(1, 8);
      for (int t = 0; t < n; t++) begin
        idle($urandom_range(0, 2));
        send_term(16'($urandom), 16'($urandom), t == n - 1);
      end
    end
    wait_drain();
    rand_ready = 0; out_ready = 1;
    idle(2);
    check("final_ready", 32'(in_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
